// File: rtl/nzcv_flag_unit_pkg.sv
// Shared definitions for the NZCV flag producer: flag bit positions, FSM encoding, reset default.
package nzcv_flag_unit_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned NZCV_W = 4;

    localparam logic [NZCV_W-1:0] RESET_NZCV_DEFAULT = 4'b0000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/nzcv_flag_unit_calc.sv
// Combinational N/Z/C/V generation from an ALU/shifter result.
module nzcv_calc
    import nzcv_flag_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] result,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              shf_c,
    input  logic              logical,
    input  logic              old_v,
    output logic [3:0]        nzcv_c
);

    always_comb begin
        nzcv_c         = '0;
        nzcv_c[FLAG_N] = result[DATA_W-1];
        nzcv_c[FLAG_Z] = (result == '0);
        nzcv_c[FLAG_C] = logical ? shf_c : alu_c;
        // logical ops leave overflow untouched
        nzcv_c[FLAG_V] = logical ? old_v : alu_v;
    end

endmodule

// File: rtl/nzcv_flag_unit.sv
// NZCV producer: one-entry staging of S-bit results, MSR writes, exception save/restore.
// Optional: define NZCV_BYPASS_EN to forward the staged flags and allow back-to-back updates.
module nzcv_flag_unit
    import nzcv_flag_unit_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter logic [3:0]  RESET_NZCV = RESET_NZCV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [DATA_W-1:0] upd_result,
    input  logic              upd_alu_c,
    input  logic              upd_alu_v,
    input  logic              upd_shf_c,
    input  logic              upd_logical,
    input  logic              upd_s,
    input  logic              upd_cond_pass,
    input  logic              msr_valid,
    output logic              msr_ready,
    input  logic [3:0]        msr_nzcv,
    input  logic              commit_en,
    input  logic              flush,
    input  logic              exc_entry,
    input  logic              exc_return,
    output logic [3:0]        nzcv,
    output logic [3:0]        nzcv_fwd,
    output logic [3:0]        saved_nzcv,
    output logic              pending
);

    stage_state_t state_q, state_d;
    logic [3:0]   stage_q, stage_d;
    logic [3:0]   nzcv_q, nzcv_d;
    logic [3:0]   saved_q, saved_d;
    logic [3:0]   newest_c;
    logic [3:0]   calc_c;
    logic         commit_c;
    logic         upd_acc_c;
    logic         msr_acc_c;
    logic         stage_load_c;

    assign newest_c = (state_q == FULL) ? stage_q : nzcv_q;

    nzcv_calc #(
        .DATA_W (DATA_W)
    ) u_calc (
        .result  (upd_result),
        .alu_c   (upd_alu_c),
        .alu_v   (upd_alu_v),
        .shf_c   (upd_shf_c),
        .logical (upd_logical),
        .old_v   (newest_c[FLAG_V]),
        .nzcv_c  (calc_c)
    );

    // State and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            stage_q <= RESET_NZCV;
            nzcv_q  <= RESET_NZCV;
            saved_q <= RESET_NZCV;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            nzcv_q  <= nzcv_d;
            saved_q <= saved_d;
        end
    end

    // Next-state and next-flag logic
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        nzcv_d       = nzcv_q;
        saved_d      = saved_q;
        upd_acc_c    = upd_valid && upd_ready;
        msr_acc_c    = msr_valid && msr_ready;
        commit_c     = (state_q == FULL) && commit_en && !flush && !exc_return;
        stage_load_c = upd_acc_c && upd_s && upd_cond_pass && !flush;

        if (flush || exc_return) begin
            state_d = EMPTY;
        end else if (stage_load_c) begin
            state_d = FULL;
            stage_d = calc_c;
        end else if (commit_c) begin
            state_d = EMPTY;
        end

        // restore beats MSR, MSR beats a same-cycle commit
        if (exc_return) begin
            nzcv_d = saved_q;
        end else if (msr_acc_c) begin
            nzcv_d = msr_nzcv;
        end else if (commit_c) begin
            nzcv_d = stage_q;
        end

        if (exc_entry && !exc_return) begin
            saved_d = commit_c ? stage_q : nzcv_q;
        end
    end

    // Handshake and flag outputs
    always_comb begin
        upd_ready = 1'b0;
        msr_ready = 1'b0;
        pending   = (state_q == FULL);
        nzcv_fwd  = nzcv_q;
        if (rst_n) begin
            msr_ready = ((state_q == EMPTY) || commit_en) && !exc_entry && !exc_return;
            upd_ready = msr_ready && !msr_valid;
        end
`ifdef NZCV_BYPASS_EN
        if (state_q == FULL) begin
            nzcv_fwd = stage_q;
        end
`else
        upd_ready = upd_ready && (state_q == EMPTY);
`endif
    end

    assign nzcv       = nzcv_q;
    assign saved_nzcv = saved_q;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Directed self-checking bench for nzcv_flag_unit (default DATA_W=32, RESET_NZCV=0000).
module tb_nzcv_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_result;
    logic        upd_alu_c;
    logic        upd_alu_v;
    logic        upd_shf_c;
    logic        upd_logical;
    logic        upd_s;
    logic        upd_cond_pass;
    logic        msr_valid;
    logic        msr_ready;
    logic [3:0]  msr_nzcv;
    logic        commit_en;
    logic        flush;
    logic        exc_entry;
    logic        exc_return;
    logic [3:0]  nzcv;
    logic [3:0]  nzcv_fwd;
    logic [3:0]  saved_nzcv;
    logic        pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nzcv_flag_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_result    (upd_result),
        .upd_alu_c     (upd_alu_c),
        .upd_alu_v     (upd_alu_v),
        .upd_shf_c     (upd_shf_c),
        .upd_logical   (upd_logical),
        .upd_s         (upd_s),
        .upd_cond_pass (upd_cond_pass),
        .msr_valid     (msr_valid),
        .msr_ready     (msr_ready),
        .msr_nzcv      (msr_nzcv),
        .commit_en     (commit_en),
        .flush         (flush),
        .exc_entry     (exc_entry),
        .exc_return    (exc_return),
        .nzcv          (nzcv),
        .nzcv_fwd      (nzcv_fwd),
        .saved_nzcv    (saved_nzcv),
        .pending       (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] res, input logic ac, input logic av,
                           input logic sc, input logic lg, input logic s, input logic ps);
        upd_valid     = 1'b1;
        upd_result    = res;
        upd_alu_c     = ac;
        upd_alu_v     = av;
        upd_shf_c     = sc;
        upd_logical   = lg;
        upd_s         = s;
        upd_cond_pass = ps;
    endtask

    initial begin
        rst_n = 1'b0; upd_valid = 1'b0; upd_result = '0; upd_alu_c = 1'b0; upd_alu_v = 1'b0;
        upd_shf_c = 1'b0; upd_logical = 1'b0; upd_s = 1'b0; upd_cond_pass = 1'b0;
        msr_valid = 1'b0; msr_nzcv = '0; commit_en = 1'b1; flush = 1'b0;
        exc_entry = 1'b0; exc_return = 1'b0;

        // reset
        tick(); tick();
        chk("rst_upd_ready", 32'(upd_ready), 32'd0);
        chk("rst_msr_ready", 32'(msr_ready), 32'd0);
        rst_n = 1'b1; #1;
        chk("rst_nzcv", 32'(nzcv), 32'h0);
        chk("rst_saved", 32'(saved_nzcv), 32'h0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("post_rst_upd_ready", 32'(upd_ready), 32'd1);
        chk("post_rst_msr_ready", 32'(msr_ready), 32'd1);

        // arithmetic update, zero result with carry -> 0110
        set_upd(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        chk("arith_ready", 32'(upd_ready), 32'd1);
        tick(); upd_valid = 1'b0; #1;
        chk("arith_pending", 32'(pending), 32'd1);
        chk("arith_nzcv_pre", 32'(nzcv), 32'h0);
`ifdef NZCV_BYPASS_EN
        chk("arith_fwd", 32'(nzcv_fwd), 32'h6);
`else
        chk("arith_fwd", 32'(nzcv_fwd), 32'h0);
`endif
        tick();
        chk("arith_pending_clr", 32'(pending), 32'd0);
        chk("arith_nzcv", 32'(nzcv), 32'h6);

        // logical update preserves V: 0001 -> 1001
        msr_valid = 1'b1; msr_nzcv = 4'b0001; #1;
        chk("msr1_ready", 32'(msr_ready), 32'd1);
        tick(); msr_valid = 1'b0; #1;
        chk("msr1_nzcv", 32'(nzcv), 32'h1);
        set_upd(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(); upd_valid = 1'b0; tick();
        chk("logic_nzcv", 32'(nzcv), 32'h9);

        // stall while FULL without commit, then flush
        commit_en = 1'b0;
        set_upd(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); #1;
        chk("hold_pending", 32'(pending), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_upd_ready", 32'(upd_ready), 32'd0);
            chk("hold_nzcv", 32'(nzcv), 32'h9);
            tick();
        end
        upd_valid = 1'b0; flush = 1'b1; commit_en = 1'b1;
        tick(); flush = 1'b0; #1;
        chk("flush_pending", 32'(pending), 32'd0);
        chk("flush_nzcv", 32'(nzcv), 32'h9);

        // MSR beats a simultaneous update, which then goes next cycle
        msr_valid = 1'b1; msr_nzcv = 4'b1111;
        set_upd(32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
        chk("msr_prio_upd_ready", 32'(upd_ready), 32'd0);
        chk("msr_prio_msr_ready", 32'(msr_ready), 32'd1);
        tick(); msr_valid = 1'b0; #1;
        chk("msr_prio_nzcv", 32'(nzcv), 32'hF);
        chk("msr_prio_upd_ready2", 32'(upd_ready), 32'd1);
        tick(); upd_valid = 1'b0; #1;
        chk("msr_prio_pending", 32'(pending), 32'd1);
        tick();
        chk("msr_prio_nzcv2", 32'(nzcv), 32'h0);

        // exception save / MSR / restore
        msr_valid = 1'b1; msr_nzcv = 4'b0100; tick(); msr_valid = 1'b0;
        exc_entry = 1'b1; set_upd(32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1); #1;
        chk("exc_upd_ready", 32'(upd_ready), 32'd0);
        chk("exc_msr_ready", 32'(msr_ready), 32'd0);
        tick(); exc_entry = 1'b0; upd_valid = 1'b0; #1;
        chk("exc_saved", 32'(saved_nzcv), 32'h4);
        chk("exc_no_stage", 32'(pending), 32'd0);
        msr_valid = 1'b1; msr_nzcv = 4'b1010; tick(); msr_valid = 1'b0; #1;
        chk("exc_msr_nzcv", 32'(nzcv), 32'hA);
        exc_return = 1'b1; tick(); exc_return = 1'b0; #1;
        chk("exc_ret_nzcv", 32'(nzcv), 32'h4);
        chk("exc_ret_saved", 32'(saved_nzcv), 32'h4);

        // S=0 and cond fail leave flags alone
        set_upd(32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        chk("s0_pending", 32'(pending), 32'd0);
        set_upd(32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); upd_valid = 1'b0; tick();
        chk("nopass_pending", 32'(pending), 32'd0);
        chk("nopass_nzcv", 32'(nzcv), 32'h4);

        // exc_entry with same-cycle commit captures staged value (1010)
        commit_en = 1'b0;
        set_upd(32'h8000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); upd_valid = 1'b0;
        commit_en = 1'b1; exc_entry = 1'b1;
        tick(); exc_entry = 1'b0; #1;
        chk("exc_commit_saved", 32'(saved_nzcv), 32'hA);
        chk("exc_commit_nzcv", 32'(nzcv), 32'hA);

        // entry and return together: return wins, saved unchanged
        msr_valid = 1'b1; msr_nzcv = 4'b0011; tick(); msr_valid = 1'b0;
        exc_entry = 1'b1; exc_return = 1'b1;
        tick(); exc_entry = 1'b0; exc_return = 1'b0; #1;
        chk("both_nzcv", 32'(nzcv), 32'hA);
        chk("both_saved", 32'(saved_nzcv), 32'hA);

        // reset mid-operation drops the stage
        commit_en = 1'b0;
        set_upd(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); upd_valid = 1'b0; #1;
        chk("midrst_pending_pre", 32'(pending), 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; commit_en = 1'b1; #1;
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_nzcv", 32'(nzcv), 32'h0);
        chk("midrst_saved", 32'(saved_nzcv), 32'h0);
        tick();
        chk("midrst_nzcv2", 32'(nzcv), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
